// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of fetch entries; clear beats push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             pop_data,
  input  logic                     clear,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding imem request FSM, prefetch FIFO and IF/ID output register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        instr_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   pc_out_q, pc_out_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, cnt_after_pop;
  fetch_entry_t  push_entry, head_entry;
  logic [31:0]   target_pc, next_pc;
  logic          space, space_after_push;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .clear     (branch_taken),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_entry       = '{pc: fetch_pc_q, instr: imem_rdata};
  assign target_pc        = branch_target & 32'hFFFF_FFFC;
  assign next_pc          = fetch_pc_q + 32'd4;
  assign fifo_pop         = !branch_taken && !stall && !fifo_empty;
  assign cnt_after_pop    = fifo_count - CW'(fifo_pop);
  assign space            = !(fifo_full && !fifo_pop);
  assign space_after_push = (cnt_after_pop + CW'(1)) < CW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fifo_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          fetch_pc_d = target_pc;
        end else if (space) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          fetch_pc_d = target_pc;
          if (imem_ack) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = S_FLUSH;
          end
        end else if (imem_ack) begin
          fifo_push  = 1'b1;
          fetch_pc_d = next_pc;
          if (space_after_push) begin
            addr_d = next_pc;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      S_FLUSH: begin
        // The stale request must still complete; its data never reaches the FIFO.
        if (branch_taken) begin
          fetch_pc_d = target_pc;
        end
        if (imem_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    if (branch_taken) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        pc_out_d = head_entry.pc;
        instr_d  = head_entry.instr;
        valid_d  = 1'b1;
      end else begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      pc_out_q   <= 32'h0;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc_out      = pc_out_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        zero_wait = 1'b1;
  logic        ack_man = 1'b0;

  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, pc_out, instruction;
  logic        req_w, ack_w, valid_w;
  logic [31:0] addr_w, rdata_w, pc_w, instr_w;

  int assert_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  assign imem_ack   = zero_wait ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  assign ack_w      = zero_wait ? req_w : ack_man;
  assign rdata_w    = addr_w ^ 32'hA5A5_0000;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .instruction(instruction), .instr_valid(instr_valid)
  );

  fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ack(ack_w), .imem_rdata(rdata_w), .pc_out(pc_w),
    .instruction(instr_w), .instr_valid(valid_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; zero_wait = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    tick(); tick();
    assert_cnt++; if (pc_out !== 32'h0) begin fail_cnt++; $display("FAIL reset_pc_out: got %h expected %h", pc_out, 32'h0); end
    assert_cnt++; if (instruction !== 32'h0) begin fail_cnt++; $display("FAIL reset_instr: got %h expected %h", instruction, 32'h0); end
    assert_cnt++; if (instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    assert_cnt++; if (imem_req !== 1'b0) begin fail_cnt++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    assert_cnt++; if (imem_addr !== 32'h0) begin fail_cnt++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
    assert_cnt++; if (addr_w !== 32'hFFFF_FFF8) begin fail_cnt++; $display("FAIL reset_addr_w: got %h expected %h", addr_w, 32'hFFFF_FFF8); end
  endtask

  task automatic test_stream();
    rst = 1'b1;
    tick();
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fail_cnt++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, 32'h0); end
    tick();
    assert_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 32'h4) begin fail_cnt++; $display("FAIL stream_latency: got valid=%b addr=%h expected valid=0 addr=%h", instr_valid, imem_addr, 32'h4); end
    for (int k = 0; k < 6; k++) begin
      tick();
      assert_cnt++;
      if (pc_out !== 32'(4*k) || instruction !== (32'(4*k) ^ 32'hA5A5_0000) || instr_valid !== 1'b1) begin
        fail_cnt++;
        $display("FAIL stream_%0d: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", k, pc_out, instruction, instr_valid, 32'(4*k), 32'(4*k) ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      assert_cnt++;
      if (pc_out !== 32'd20 || instruction !== 32'hA5A5_0014 || instr_valid !== 1'b1) begin
        fail_cnt++;
        $display("FAIL stall_hold_%0d: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", i, pc_out, instruction, instr_valid, 32'd20, 32'hA5A5_0014);
      end
    end
    assert_cnt++; if (imem_req !== 1'b0) begin fail_cnt++; $display("FAIL stall_req_drop: got %b expected 0", imem_req); end
    stall = 1'b0;
    tick();
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd32) begin fail_cnt++; $display("FAIL stall_refetch: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, 32'd32); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      assert_cnt++;
      if (pc_out !== 32'(24 + 4*i) || instruction !== (32'(24 + 4*i) ^ 32'hA5A5_0000) || instr_valid !== 1'b1) begin
        fail_cnt++;
        $display("FAIL stall_resume_%0d: got pc=%h valid=%b expected pc=%h valid=1", i, pc_out, instr_valid, 32'(24 + 4*i));
      end
    end
  endtask

  task automatic test_delayed_ack();
    zero_wait = 1'b0; ack_man = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      tick();
      assert_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*r)) begin fail_cnt++; $display("FAIL delay_req_a_%0d: got req=%b addr=%h expected req=1 addr=%h", r, imem_req, imem_addr, 32'(4*r)); end
      assert_cnt++;
      if (r == 0) begin
        if (instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL delay_bubble0: got valid=%b expected 0", instr_valid); end
      end else if (instr_valid !== 1'b1 || pc_out !== 32'(4*(r-1)) || instruction !== (32'(4*(r-1)) ^ 32'hA5A5_0000)) begin
        fail_cnt++; $display("FAIL delay_out_%0d: got pc=%h instr=%h valid=%b expected pc=%h valid=1", r, pc_out, instruction, instr_valid, 32'(4*(r-1)));
      end
      tick();
      assert_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*r)) begin fail_cnt++; $display("FAIL delay_req_b_%0d: got req=%b addr=%h expected req=1 addr=%h", r, imem_req, imem_addr, 32'(4*r)); end
      assert_cnt++;
      if (instr_valid !== 1'b0 || instruction !== 32'h0) begin fail_cnt++; $display("FAIL delay_gap_%0d: got valid=%b instr=%h expected valid=0 instr=0", r, instr_valid, instruction); end
      ack_man = 1'b1;
      tick();
      ack_man = 1'b0;
      assert_cnt++;
      if (imem_addr !== 32'(4*(r+1)) || instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL delay_ack_%0d: got addr=%h valid=%b expected addr=%h valid=0", r, imem_addr, instr_valid, 32'(4*(r+1))); end
    end
    tick();
    assert_cnt++; if (pc_out !== 32'd8 || instr_valid !== 1'b1) begin fail_cnt++; $display("FAIL delay_last: got pc=%h valid=%b expected pc=%h valid=1", pc_out, instr_valid, 32'd8); end
  endtask

  task automatic test_branch_wait();
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    assert_cnt++; if (instr_valid !== 1'b0 || instruction !== 32'h0) begin fail_cnt++; $display("FAIL br_bubble: got valid=%b instr=%h expected valid=0 instr=0", instr_valid, instruction); end
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin fail_cnt++; $display("FAIL br_old_req_held: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, 32'd12); end
    tick();
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) begin fail_cnt++; $display("FAIL br_flush_wait: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, 32'd12); end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    assert_cnt++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL br_flush_ack: got req=%b valid=%b expected req=0 valid=0", imem_req, instr_valid); end
    tick();
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL br_new_req: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", imem_req, imem_addr, instr_valid, 32'h100); end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    assert_cnt++; if (instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL br_pre_out: got valid=%b expected 0", instr_valid); end
    tick();
    assert_cnt++; if (pc_out !== 32'h100 || instruction !== 32'hA5A5_0100 || instr_valid !== 1'b1) begin fail_cnt++; $display("FAIL br_target_out: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", pc_out, instruction, instr_valid, 32'h100, 32'hA5A5_0100); end
  endtask

  task automatic test_branch_ack_stall();
    stall = 1'b1; ack_man = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0; ack_man = 1'b0;
    assert_cnt++; if (instr_valid !== 1'b0 || instruction !== 32'h0) begin fail_cnt++; $display("FAIL bas_bubble: got valid=%b instr=%h expected valid=0 instr=0", instr_valid, instruction); end
    assert_cnt++; if (imem_req !== 1'b0) begin fail_cnt++; $display("FAIL bas_req_drop: got %b expected 0", imem_req); end
    tick();
    assert_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin fail_cnt++; $display("FAIL bas_new_req: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", imem_req, imem_addr, instr_valid, 32'h200); end
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    assert_cnt++; if (instr_valid !== 1'b0 || imem_addr !== 32'h204) begin fail_cnt++; $display("FAIL bas_stalled: got valid=%b addr=%h expected valid=0 addr=%h", instr_valid, imem_addr, 32'h204); end
    stall = 1'b0;
    tick();
    assert_cnt++; if (pc_out !== 32'h200 || instruction !== 32'hA5A5_0200 || instr_valid !== 1'b1) begin fail_cnt++; $display("FAIL bas_out: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", pc_out, instruction, instr_valid, 32'h200, 32'hA5A5_0200); end
  endtask

  task automatic test_wrap_and_reset();
    stall = 1'b0; branch_taken = 1'b0; ack_man = 1'b0; zero_wait = 1'b1; rst = 1'b0;
    tick();
    assert_cnt++; if (req_w !== 1'b0 || addr_w !== 32'hFFFF_FFF8) begin fail_cnt++; $display("FAIL wrap_reset: got req=%b addr=%h expected req=0 addr=%h", req_w, addr_w, 32'hFFFF_FFF8); end
    rst = 1'b1;
    tick();
    assert_cnt++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFF8) begin fail_cnt++; $display("FAIL wrap_first_req: got req=%b addr=%h expected req=1 addr=%h", req_w, addr_w, 32'hFFFF_FFF8); end
    tick();
    tick();
    assert_cnt++; if (pc_w !== 32'hFFFF_FFF8 || instr_w !== 32'h5A5A_FFF8 || valid_w !== 1'b1) begin fail_cnt++; $display("FAIL wrap_out0: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", pc_w, instr_w, valid_w, 32'hFFFF_FFF8, 32'h5A5A_FFF8); end
    assert_cnt++; if (addr_w !== 32'h0) begin fail_cnt++; $display("FAIL wrap_addr: got %h expected %h", addr_w, 32'h0); end
    tick();
    assert_cnt++; if (pc_w !== 32'hFFFF_FFFC || instr_w !== 32'h5A5A_FFFC) begin fail_cnt++; $display("FAIL wrap_out1: got pc=%h instr=%h expected pc=%h instr=%h", pc_w, instr_w, 32'hFFFF_FFFC, 32'h5A5A_FFFC); end
    tick();
    assert_cnt++; if (pc_w !== 32'h0 || instr_w !== 32'hA5A5_0000 || valid_w !== 1'b1) begin fail_cnt++; $display("FAIL wrap_out2: got pc=%h instr=%h valid=%b expected pc=%h instr=%h valid=1", pc_w, instr_w, valid_w, 32'h0, 32'hA5A5_0000); end
    rst = 1'b0;
    tick();
    assert_cnt++; if (pc_w !== 32'h0 || instr_w !== 32'h0 || valid_w !== 1'b0 || req_w !== 1'b0 || addr_w !== 32'hFFFF_FFF8) begin fail_cnt++; $display("FAIL midreq_reset_w: got pc=%h instr=%h valid=%b req=%b addr=%h expected 0/0/0/0/%h", pc_w, instr_w, valid_w, req_w, addr_w, 32'hFFFF_FFF8); end
    assert_cnt++; if (pc_out !== 32'h0 || instruction !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin fail_cnt++; $display("FAIL midreq_reset: got pc=%h instr=%h valid=%b req=%b addr=%h expected all 0", pc_out, instruction, instr_valid, imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_delayed_ack();
    test_branch_wait();
    test_branch_ack_stall();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: holds the fetch PC, issues word reads to instruction memory over a req/ack handshake, buffers returned words in a small prefetch FIFO and presents `pc_out`/`instruction` to the IF/ID pipeline register. It is the producer side of the IF/ID interface. It honours a decode-stage stall and an execute-stage branch redirect, and inserts NOP bubbles when no instruction is ready.

## Interface
Parameters:
- `DEPTH`, 2: prefetch FIFO entries, power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address; must be word aligned.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `stall` in 1: hold outputs, no pop.
- `branch_taken` in 1: redirect request, one-cycle pulse.
- `branch_target` in 32: redirect address; bits [1:0] forced to 0.
- `imem_req` out 1: read request, registered.
- `imem_addr` out 32: read address, registered, word aligned.
- `imem_ack` in 1: read complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `pc_out` out 32: PC of the presented instruction.
- `instruction` out 32: presented instruction, or NOP.
- `instr_valid` out 1: 1 = real instruction, 0 = bubble.

## Operation
- States: S_IDLE (no request), S_WAIT (request outstanding), S_FLUSH (request outstanding, data to be discarded). At most one outstanding request.
- Space = (FIFO count after this cycle's pop) < DEPTH.
- S_IDLE with space and no redirect → S_WAIT. Set `imem_req`=1 and `imem_addr`=fetch_pc.
- S_WAIT, `imem_ack`=1:
  - push {fetch_pc, imem_rdata}; fetch_pc += 4.
  - If space remains after the push, stay in S_WAIT with `imem_addr`=new fetch_pc (back-to-back fetch).
  - Otherwise → S_IDLE with `imem_req`=0.
- `imem_req` and `imem_addr` stay stable until ack; a request is never withdrawn except by reset.
- `branch_taken`:
  - FIFO cleared.
  - fetch_pc ← `branch_target`.
  - Output register ← bubble on the same edge. Redirect overrides `stall`.
  - In S_WAIT without ack → S_FLUSH. The old request is completed and its data discarded.
  - In S_WAIT with ack in the same cycle → data discarded, → S_IDLE.
  - In S_IDLE → stays S_IDLE; the new fetch is issued next cycle.
- S_FLUSH:
  - On ack → S_IDLE, data dropped, fetch_pc unchanged.
  - A further `branch_taken` in S_FLUSH only updates fetch_pc.
- Output stage, evaluated on each edge when no redirect:
  - `stall`=1: `pc_out`, `instruction` and `instr_valid` hold.
  - `stall`=0 and FIFO non-empty: pop the head into `pc_out`/`instruction`; `instr_valid`=1.
  - `stall`=0 and FIFO empty: `instruction`=NOP, `instr_valid`=0, `pc_out` holds.
- Push and pop in the same cycle are legal at any count, including full.
- fetch_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 (mod 2^32).

## Timing
- Reset (`rst`=0 at a posedge):
  - `pc_out`=0, `instruction`=NOP, `instr_valid`=0.
  - `imem_req`=0, `imem_addr`=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty, state S_IDLE.
  - Reset mid-request abandons it; the memory must accept a dropped request.
- First edge with `rst`=1: `imem_req` rises.
- Ack sampled at edge N → entry in FIFO after N → on outputs after N+1 if not stalled. Fetch-to-output latency is 2 edges after ack.
- Zero-wait memory (ack tied high with req): one instruction per cycle sustained.
- Branch at edge N: bubble on outputs after N. `imem_req` with `imem_addr`=target after N+1 if the state was S_IDLE, or one edge after the flush ack otherwise.
- Outputs are registered on posedge and are stable for the downstream IF/ID negedge capture.

## Structure
- Package `fetch_pkg`:
  - `NOP` = 32'h0000_0000
  - `fetch_state_t` enum (S_IDLE, S_WAIT, S_FLUSH)
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}
- Sub-module `fetch_fifo`:
  - Synchronous FIFO of `fetch_entry_t`, DEPTH entries.
  - Ports: push, pop, clear, full, empty, count.
  - `clear` has priority over push and pop.
- Top level holds the FSM, fetch_pc and the output register.

## Test plan
- Reset, then `imem_ack` tied to `imem_req`, `imem_rdata`=addr^32'hA5A5_0000 → `pc_out` 0,4,8,… on consecutive cycles with matching `instruction`, `instr_valid`=1.
- Ack delayed 3 cycles per request → `imem_req`/`imem_addr` stable until ack; two-edge latency from ack to output; bubbles with `instr_valid`=0 in between.
- `stall` held 5 cycles with zero-wait memory → outputs frozen, FIFO fills to DEPTH, `imem_req` drops; on release the PC sequence continues with no loss or duplication.
- `branch_taken` with target 32'h0000_0103 while in S_WAIT → bubble next edge, old data discarded, next request at 32'h0000_0100, `pc_out`=32'h100 after it.
- `branch_taken` together with ack, and `branch_taken` together with `stall`=1 → ack data dropped; bubble output despite stall.
- RESET_PC=32'hFFFF_FFF8 → `pc_out` FFFF_FFF8, FFFF_FFFC, 0000_0000; `rst`=0 mid-request → all outputs return to reset values on that edge.
